debounce_scheduler: RTL and testbench
=====================================

# debounce_scheduler

Multi-channel button conditioner serving the front-panel inputs with one shared debounce datapath. Each raw input is synchronized, and a single incrementer/comparator is time-shared across all channels by a scan FSM. Stable level changes are committed to `btn_state` and reported as press/release events through a round-robin arbiter onto one valid/ready event port. The block sits between the pad inputs and the control logic that consumes key/button events.

## Interface
- `NUM_CH`, default 4: number of input channels, 2..16.
- `STABLE_TICKS`, default 128: number of consecutive sample ticks a new level must hold before it is committed, 2..255.
- `PRESCALE`, default 16: clocks per sample tick; must be ≥ `NUM_CH`+1.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: sampling enable.
- `btn_in` input `NUM_CH`: raw asynchronous button levels.
- `btn_state` output `NUM_CH`: committed debounced levels.
- `evt_valid` output 1: event available.
- `evt_ready` input 1: consumer accepts the event when high together with `evt_valid`.
- `evt_ch` output `max(1,$clog2(NUM_CH))`: channel index of the event.
- `evt_press` output 1: 1 = rising commit (press), 0 = falling commit (release).
- `overrun` output 1: sticky flag, set when a pending event is overwritten; cleared only by reset.

## Operation
- Synchronizer: two flops per channel, giving `sync[i]`.
- Prescaler: counts 0..`PRESCALE`-1 while `enable`=1 and pulses `tick` on wrap.
- Scan FSM, states IDLE and SCAN:
  - IDLE→SCAN on `tick`, with `ptr` set to 0.
  - In SCAN, channel `ptr` is serviced each clock and `ptr` increments.
  - After servicing `NUM_CH`-1, SCAN→IDLE.
- Per-channel counter width is `$clog2(STABLE_TICKS)`. Servicing channel i:
  - If `sync[i]`==`btn_state[i]`: counter ← 0.
  - Else, if counter+1 == `STABLE_TICKS`: commit. `btn_state[i]` ← `sync[i]`, counter ← 0, `pend[i]` ← 1, `pol[i]` ← `sync[i]`.
  - Otherwise: counter ← counter+1.
- A mismatch interrupted by a single matching sample restarts the count from 0.
- Commit while `pend[i]` is already 1: `pol[i]` is overwritten and `overrun` ← 1.
- Event output register:
  - Loads when empty, or in the same cycle the current event is accepted.
  - Source is the round-robin winner among `pend[]`, searching from last-granted+1 with wraparound. After reset the search starts at channel 0.
  - On load: `pend[winner]` ← 0, `evt_ch`/`evt_press` ← winner / `pol[winner]`.
  - A commit and a grant on the same channel in the same cycle: the commit wins. `pend` stays 1 and carries the new polarity; the granted event carries the old polarity.
- `enable`=0:
  - Prescaler and all per-channel counters clear; the FSM finishes any in-progress scan, then stays in IDLE.
  - `btn_state`, `pend` and the event port keep operating.

## Timing
- Reset values:
  - `btn_state`=0, `evt_valid`=0, `evt_ch`=0, `evt_press`=0, `overrun`=0.
  - All counters, `pend`, prescaler and `ptr` = 0; FSM in IDLE.
- Reset asserted mid-scan or mid-handshake aborts everything immediately; pending events are lost.
- A button held high through reset commits a press `STABLE_TICKS` ticks after reset release.
- Commit latency from a clean input step: 2 synchronizer clocks + `STABLE_TICKS` ticks, ±1 tick phase. This is `STABLE_TICKS`·`PRESCALE` clocks, with jitter up to `PRESCALE`+`NUM_CH`.
- `btn_state[i]` updates on the clock that services channel i.
- `evt_valid` rises the clock after commit if the output register is empty.
- Once asserted, `evt_valid`/`evt_ch`/`evt_press` are held stable until accepted.
- Back-to-back throughput with `evt_ready` held at 1: one event per clock.

## Structure
- Package `debounce_pkg`:
  - scan state enum (`ST_IDLE`, `ST_SCAN`)
  - event struct (`ch`, `press`)
  - width helper constant function for channel index and counter widths.
- Sub-module `rr_arbiter`: parameterized `N`; inputs `req[N]`, `advance`; outputs `grant_idx`, `grant_valid`; holds the last-granted pointer.
- Top level contains the synchronizers, prescaler, scan FSM, counter array and output register.

## Test plan
All scenarios use `NUM_CH`=4, `STABLE_TICKS`=4, `PRESCALE`=8.
1. Press: hold `btn_in`=0001 from reset release, `evt_ready`=1. Expect `btn_state`=0001 and one event {ch 0, press 1} at 32±13 clocks. No further events.
2. Bounce: toggle `btn_in[2]` every 12 clocks for 200 clocks, then hold 1. Expect no event during bouncing, then exactly one {ch 2, press 1} about 32 clocks after the final edge.
3. Fairness: `btn_in`=1111 simultaneously, `evt_ready`=0 until all four are pending, then ready=1. Expect events for channels 0,1,2,3 on consecutive clocks; a second burst starts the search at channel 0 after channel 3's grant.
4. Backpressure/overrun: press then release ch 1 with `evt_ready`=0 throughout. Expect the first event held stable {1,1}, `overrun`=1, and after ready a second event {1,0}.
5. Reset mid-operation: deassert `rst_n` while ch 3 is counting and an event is valid. Expect all outputs 0 asynchronously. After release with `btn_in[3]`=1, expect a fresh press after 4 ticks.
6. Enable gating: `enable`=0 with `btn_in`=0100 for 200 clocks. Expect no commit. Raising `enable` yields a press after 4 ticks.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_scheduler shared types
// scan states, event bundle, width helper
package debounce_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_st_t;

  typedef struct packed {
    logic [3:0] ch;
    logic       press;
  } evt_t;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// round-robin pick over pending channels
// search starts one past the last grant
module rr_arbiter
  import debounce_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic                   advance,
  output logic [width_of(N)-1:0] grant_idx,
  output logic                   grant_valid
);

  localparam int IW = width_of(N);

  logic [IW-1:0] last_q;
  int            j;

  // first requester after last grant, wrapping
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(last_q) + i) % N;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

  // last-granted pointer; N-1 makes channel 0 first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IW'(N - 1);
    end else if (advance && grant_valid) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/debounce_scheduler.sv
// multi-channel debouncer, one shared counter path
// commits stable levels and queues press/release events
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int STABLE_TICKS = 128,
  parameter int PRESCALE     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           btn_in,
  output logic [NUM_CH-1:0]           btn_state,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [width_of(NUM_CH)-1:0] evt_ch,
  output logic                        evt_press,
  output logic                        overrun
);

  localparam int CHW = width_of(NUM_CH);
  localparam int CW  = width_of(STABLE_TICKS);
  localparam int PW  = width_of(PRESCALE);

  localparam logic [CW:0]    LIM  = (CW + 1)'(STABLE_TICKS);
  localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);
  localparam logic [CHW-1:0] LAST = CHW'(NUM_CH - 1);

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [PW-1:0]     pre_q;
  logic              tick;
  scan_st_t          state_q;
  scan_st_t          state_d;
  logic [CHW-1:0]    ptr_q;
  logic [CHW-1:0]    ptr_d;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pol_q;
  evt_t              evt_q;
  logic              evt_valid_q;

  logic              svc;
  logic              cur_sync;
  logic              match;
  logic [CW:0]       cnt_inc;
  logic              commit;
  logic              load;
  logic              take;
  logic [CHW-1:0]    gidx;
  logic              gvalid;

  // two-flop synchronizer per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  assign tick = enable && (pre_q == PMAX);

  // sample-tick prescaler, held at 0 when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (!enable || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  // scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // scan next-state: one channel per clock
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
        end
      end
      ST_SCAN: begin
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + CHW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // shared incrementer/comparator for the serviced channel
  always_comb begin
    svc      = (state_q == ST_SCAN) && enable;
    cur_sync = sync2_q[ptr_q];
    match    = (cur_sync == btn_state[ptr_q]);
    cnt_inc  = {1'b0, cnt_q[ptr_q]} + (CW + 1)'(1);
    commit   = svc && !match && (cnt_inc == LIM);
  end

  // per-channel stability counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (!enable) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (svc) begin
      if (match || commit) begin
        cnt_q[ptr_q] <= '0;
      end else begin
        cnt_q[ptr_q] <= cnt_inc[CW-1:0];
      end
    end
  end

  // committed levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_state <= '0;
    end else if (commit) begin
      btn_state[ptr_q] <= cur_sync;
    end
  end

  assign load = !evt_valid_q || evt_ready;
  assign take = load && gvalid;

  rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (pend_q),
    .advance    (take),
    .grant_idx  (gidx),
    .grant_valid(gvalid)
  );

  // pending flags, polarity and output register;
  // a same-cycle commit overrides the grant's clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pol_q       <= '0;
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (take) begin
        pend_q[gidx] <= 1'b0;
        evt_q        <= '{ch: 4'(gidx), press: pol_q[gidx]};
        evt_valid_q  <= 1'b1;
      end else if (load) begin
        evt_valid_q  <= 1'b0;
      end
      if (commit) begin
        pend_q[ptr_q] <= 1'b1;
        pol_q[ptr_q]  <= cur_sync;
        if (pend_q[ptr_q] && !(take && gidx == ptr_q)) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = CHW'(evt_q.ch);
  assign evt_press = evt_q.press;

endmodule

// File: tb/tb_debounce_scheduler.sv
// directed bench for debounce_scheduler
// NUM_CH=4, STABLE_TICKS=4, PRESCALE=8
module tb_debounce_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] btn_in;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_press;
  logic       overrun;

  typedef struct {
    int ch;
    int press;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  t0;
  int  n_cmp = 0;
  int  n_err = 0;
  int  stab_err = 0;
  int  pv, pr, pc, pp;

  debounce_scheduler #(
    .NUM_CH      (4),
    .STABLE_TICKS(4),
    .PRESCALE    (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .btn_in   (btn_in),
    .btn_state(btn_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch   (evt_ch),
    .evt_press(evt_press),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // record accepted events and hold-stability
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      pv = 0;
    end else begin
      if (pv == 1 && pr == 0) begin
        if (evt_valid !== 1'b1 || int'(evt_ch) != pc ||
            int'(evt_press) != pp)
          stab_err++;
      end
      if (evt_valid && evt_ready) begin
        e.ch    = int'(evt_ch);
        e.press = int'(evt_press);
        e.cyc   = cyc;
        q.push_back(e);
      end
      pv = int'(evt_valid);
      pr = int'(evt_ready);
      pc = int'(evt_ch);
      pp = int'(evt_press);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] b, input logic r,
                          input logic e);
    rst_n     = 1'b0;
    btn_in    = b;
    evt_ready = r;
    enable    = e;
    clks(3);
    q.delete();
    rst_n = 1'b1;
    t0    = cyc;
  endtask

  task automatic chk_ev(input string tag, input int idx,
                        input int ch, input int press);
    if (idx < q.size()) begin
      chk({tag, "_ch"}, q[idx].ch, ch);
      chk({tag, "_press"}, q[idx].press, press);
    end else begin
      chk({tag, "_missing"}, q.size(), idx + 1);
    end
  endtask

  task automatic chk_lat(input string tag, input int idx);
    int lat;
    lat = (idx < q.size()) ? q[idx].cyc - t0 : -1;
    chk(tag, int'(lat >= 19 && lat <= 45), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    btn_in    = 4'b0000;
    evt_ready = 1'b1;

    // 1: press from reset release
    do_reset(4'b0001, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_state", int'(btn_state), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ch", int'(evt_ch), 0);
    chk("rst_press", int'(evt_press), 0);
    chk("rst_ovr", int'(overrun), 0);
    do_reset(4'b0001, 1'b1, 1'b1);
    clks(100);
    chk("t1_state", int'(btn_state), 1);
    chk("t1_count", q.size(), 1);
    chk_ev("t1_ev", 0, 0, 1);
    chk_lat("t1_lat", 0);

    // 2: bounce on ch 2, then settle high
    do_reset(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      btn_in[2] = ~btn_in[2];
      clks(12);
    end
    chk("t2_bounce_cnt", q.size(), 0);
    chk("t2_bounce_st", int'(btn_state), 0);
    btn_in[2] = 1'b1;
    t0 = cyc;
    clks(80);
    chk("t2_count", q.size(), 1);
    chk_ev("t2_ev", 0, 2, 1);
    chk_lat("t2_lat", 0);
    chk("t2_state", int'(btn_state), 4);

    // 3: fairness across all channels
    do_reset(4'b1111, 1'b0, 1'b1);
    clks(60);
    chk("t3_hold_valid", int'(evt_valid), 1);
    chk("t3_hold_ch", int'(evt_ch), 0);
    evt_ready = 1'b1;
    clks(8);
    chk("t3_count", q.size(), 4);
    for (int i = 0; i < 4; i++) chk_ev("t3_ev", i, i, 1);
    if (q.size() == 4) chk("t3_b2b", q[3].cyc - q[0].cyc, 3);
    evt_ready = 1'b0;
    btn_in    = 4'b0000;
    clks(60);
    q.delete();
    evt_ready = 1'b1;
    clks(8);
    chk("t3b_count", q.size(), 4);
    for (int i = 0; i < 4; i++) chk_ev("t3b_ev", i, i, 0);

    // 4: backpressure and overrun on ch 1
    do_reset(4'b0010, 1'b0, 1'b1);
    clks(60);
    btn_in = 4'b0000;
    clks(60);
    chk("t4_no_ovr", int'(overrun), 0);
    btn_in = 4'b0010;
    clks(60);
    btn_in = 4'b0000;
    clks(60);
    chk("t4_valid", int'(evt_valid), 1);
    chk("t4_ch", int'(evt_ch), 1);
    chk("t4_press", int'(evt_press), 1);
    chk("t4_ovr", int'(overrun), 1);
    evt_ready = 1'b1;
    clks(5);
    chk("t4_count", q.size(), 2);
    chk_ev("t4_ev0", 0, 1, 1);
    chk_ev("t4_ev1", 1, 1, 0);

    // 5: reset mid-operation
    do_reset(4'b0001, 1'b0, 1'b1);
    clks(60);
    btn_in = 4'b1001;
    clks(20);
    chk("t5_pre_valid", int'(evt_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_state", int'(btn_state), 0);
    chk("t5_valid", int'(evt_valid), 0);
    chk("t5_press", int'(evt_press), 0);
    chk("t5_ch", int'(evt_ch), 0);
    do_reset(4'b1000, 1'b1, 1'b1);
    clks(60);
    chk("t5_count", q.size(), 1);
    chk_ev("t5_ev", 0, 3, 1);
    chk_lat("t5_lat", 0);
    chk("t5_after", int'(btn_state), 8);

    // 6: enable gating
    do_reset(4'b0100, 1'b1, 1'b0);
    clks(200);
    chk("t6_off_cnt", q.size(), 0);
    chk("t6_off_st", int'(btn_state), 0);
    enable = 1'b1;
    t0     = cyc;
    clks(60);
    chk("t6_count", q.size(), 1);
    chk_ev("t6_ev", 0, 2, 1);
    chk_lat("t6_lat", 0);

    chk("hold_stable", stab_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
